// File: rtl/fetch_unit_pkg.sv
// fetch_unit shared definitions.
// Default widths and the fetch reset vector.
package fetch_unit_pkg;

  localparam int WORD_SIZE_D = 32;
  localparam int ADDR_BITS_D = 8;
  localparam int DEPTH_D     = 4;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit bus: imem port, redirect input,
// decode handshake and debug taps.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_BITS = ADDR_BITS_D,
  parameter int DEPTH     = DEPTH_D
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                 imem_req;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [WORD_SIZE-1:0] imem_rdata;
  logic                 redirect;
  logic [WORD_SIZE-1:0] redirect_pc;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [WORD_SIZE-1:0] instr_out;
  logic [WORD_SIZE-1:0] instr_pc;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [CW-1:0]        fifo_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready,
    output fetch_pc, fifo_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready,
    input  fetch_pc, fifo_count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with flush; head read from the
// read pointer, pointers carry an extra wrap bit.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 2 * WORD_SIZE_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush and reset empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, in-flight
// tracking, request throttling and redirect kill.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_D,
  parameter int ADDR_BITS = ADDR_BITS_D,
  parameter int DEPTH     = DEPTH_D
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WORD_SIZE-1:0]   pc;
  logic                   inflight;
  logic [WORD_SIZE-1:0]   inflight_pc;
  logic [CW-1:0]          cnt;
  logic [CW:0]            sum;
  logic                   req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [2*WORD_SIZE-1:0] head;

  assign sum  = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign req  = !rst && !bus.redirect
             && (sum < (CW+1)'(DEPTH));
  assign push = inflight && !bus.redirect && !full;
  assign pop  = !empty && bus.instr_ready
             && !bus.redirect;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc[ADDR_BITS+1:2];
  assign bus.fetch_pc    = pc;
  assign bus.fifo_count  = cnt;
  assign bus.instr_valid = !empty;
  assign {bus.instr_out, bus.instr_pc} = head;

  // PC and in-flight tracking; redirect beats request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= WORD_SIZE'(FETCH_RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      pc       <= {bus.redirect_pc[WORD_SIZE-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (req) begin
      pc          <= pc + WORD_SIZE'(4);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .din   ({bus.imem_rdata, inflight_pc}),
    .pop   (pop),
    .dout  (head),
    .count (cnt),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// fetch_unit bench: per-cycle vector table plus
// backpressure, redirect-kill and reset sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fetch_unit_if #(.WORD_SIZE(32), .ADDR_BITS(8),
                  .DEPTH(4)) bus ();

  fetch_unit #(.WORD_SIZE(32), .ADDR_BITS(8),
               .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a is a*0x01010101.
  always @(posedge clk) begin
    if (bus.imem_req)
      bus.imem_rdata <= {4{bus.imem_addr}};
  end

  function automatic logic [31:0] wexp(
    input logic [31:0] pc);
    logic [7:0] a;
    a = pc[9:2];
    return {4{a}};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, settle 1ns.
  task automatic cyc(input logic r, input logic rdy,
                     input logic rd,
                     input logic [31:0] rpc);
    @(negedge clk);
    rst             = r;
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #1;
  endtask

  typedef struct {
    logic        r;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt [17];
  logic [31:0] got [$];

  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata  = '0;

    vt[0]  = '{1,1,0,0,     0,'h00,0,0,     0};
    vt[1]  = '{0,1,0,0,     1,'h00,0,0,     0};
    vt[2]  = '{0,1,0,0,     1,'h01,0,0,     0};
    vt[3]  = '{0,1,0,0,     1,'h02,1,'h0,   1};
    vt[4]  = '{0,1,0,0,     1,'h03,1,'h4,   1};
    vt[5]  = '{0,1,0,0,     1,'h04,1,'h8,   1};
    vt[6]  = '{0,1,1,'h43,  0,'h05,1,'hC,   1};
    vt[7]  = '{0,1,0,0,     1,'h10,0,0,     0};
    vt[8]  = '{0,1,0,0,     1,'h11,0,0,     0};
    vt[9]  = '{0,1,0,0,     1,'h12,1,'h40,  1};
    vt[10] = '{0,1,0,0,     1,'h13,1,'h44,  1};
    vt[11] = '{0,1,1,'h3FC, 0,'h14,1,'h48,  1};
    vt[12] = '{0,1,0,0,     1,'hFF,0,0,     0};
    vt[13] = '{0,1,0,0,     1,'h00,0,0,     0};
    vt[14] = '{0,1,0,0,     1,'h01,1,'h3FC, 1};
    vt[15] = '{0,1,0,0,     1,'h02,1,'h400, 1};
    vt[16] = '{0,1,0,0,     1,'h03,1,'h404, 1};

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset fetch_pc", bus.fetch_pc, 32'h0);

    // Table: streaming, redirect 0x43, addr wrap.
    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].r, vt[i].rdy, vt[i].rd, vt[i].rpc);
      chk($sformatf("v%0d req", i),
          32'(bus.imem_req), 32'(vt[i].req));
      chk($sformatf("v%0d addr", i),
          32'(bus.imem_addr), vt[i].addr);
      chk($sformatf("v%0d valid", i),
          32'(bus.instr_valid), 32'(vt[i].vld));
      chk($sformatf("v%0d count", i),
          32'(bus.fifo_count), vt[i].cnt);
      if (vt[i].vld) begin
        chk($sformatf("v%0d pc", i),
            bus.instr_pc, vt[i].pc);
        chk($sformatf("v%0d word", i),
            bus.instr_out, wexp(vt[i].pc));
      end
    end

    // Backpressure: exactly four requests then stall.
    cyc(1, 0, 0, 0);
    got.delete();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.imem_req) got.push_back(32'(bus.imem_addr));
    end
    chk("bp nreq", got.size(), 4);
    foreach (got[k]) chk("bp addr", got[k], k);
    chk("bp full count", 32'(bus.fifo_count), 4);
    chk("bp req low", 32'(bus.imem_req), 0);
    cyc(0, 1, 0, 0);
    chk("bp first rdy req", 32'(bus.imem_req), 0);
    got.delete();
    if (bus.instr_valid) got.push_back(bus.instr_pc);
    cyc(0, 1, 0, 0);
    chk("bp resume req", 32'(bus.imem_req), 1);
    for (int i = 0; i < 10 && got.size() < 5; i++) begin
      if (bus.instr_valid) begin
        chk("bp word", bus.instr_out,
            wexp(bus.instr_pc));
        got.push_back(bus.instr_pc);
      end
      if (got.size() < 5) cyc(0, 1, 0, 0);
    end
    chk("bp ndeliv", got.size(), 5);
    foreach (got[k]) chk("bp pc", got[k], 4 * k);

    // Redirect with 3 buffered and 1 in flight.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    chk("rd pre count", 32'(bus.fifo_count), 3);
    chk("rd req", 32'(bus.imem_req), 0);
    got.delete();
    begin
      int first;
      first = -1;
      for (int i = 0; i < 10 && got.size() < 3; i++) begin
        cyc(0, 1, 0, 0);
        if (i == 0) begin
          chk("rd flush count", 32'(bus.fifo_count), 0);
          chk("rd flush valid",
              32'(bus.instr_valid), 0);
        end
        if (bus.instr_valid) begin
          if (first < 0) first = i;
          got.push_back(bus.instr_pc);
        end
      end
      chk("rd first cycle", 32'(first), 2);
    end
    chk("rd ndeliv", got.size(), 3);
    foreach (got[k])
      chk("rd pc", got[k], 32'h40 + 4 * k);

    // Reset pulse mid-operation.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("rs pre count", 32'(bus.fifo_count), 3);
    cyc(1, 0, 0, 0);
    chk("rs req in rst", 32'(bus.imem_req), 0);
    cyc(0, 0, 0, 0);
    chk("rs valid", 32'(bus.instr_valid), 0);
    chk("rs count", 32'(bus.fifo_count), 0);
    chk("rs fetch_pc", bus.fetch_pc, 0);
    chk("rs addr", 32'(bus.imem_addr), 0);
    cyc(0, 1, 0, 0);
    chk("rs no residual", 32'(bus.fifo_count), 0);
    got.delete();
    for (int i = 0; i < 6 && got.size() < 1; i++) begin
      cyc(0, 1, 0, 0);
      if (bus.instr_valid) begin
        got.push_back(bus.instr_pc);
        chk("rs word", bus.instr_out, 32'h0);
      end
    end
    chk("rs ndeliv", got.size(), 1);
    if (got.size() > 0) chk("rs pc", got[0], 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
